// File: rtl/aer_pkg.sv
// Shared types and helpers for the AER transmit arbiter.
// The state enum, the address-width helper and the polarity encodings live here.
package aer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GRANT,
      ST_SEND,
      ST_RELEASE,
      ST_DONE
   } aer_tx_state_t;

   localparam logic POL_UP   = 1'b0;
   localparam logic POL_DOWN = 1'b1;

   function automatic int aer_addr_w(input int n_ch);
      return $clog2(n_ch) + 1;
   endfunction

endpackage

// File: rtl/aer_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer, wrapping.
// Produces a one-hot pick, its binary index and an any-request flag.
module aer_rr_arbiter #(
   parameter int N_CH  = 4,
   parameter int IDX_W = 2
) (
   input  logic [N_CH-1:0]  i_req,
   input  logic [IDX_W-1:0] i_rr_ptr,
   output logic [N_CH-1:0]  o_pick,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   always_comb begin
      int j;
      j      = 0;
      o_pick = '0;
      o_idx  = '0;
      o_any  = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         j = (int'(i_rr_ptr) + i) % N_CH;
         if (!o_any && i_req[j]) begin
            o_pick[j] = 1'b1;
            o_idx     = IDX_W'(j);
            o_any     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/aer_tx_arbiter.sv
// Round-robin arbiter and four-phase AER transmitter for the per-channel event FSMs.
// Optional ack timeout with sticky error flag is built when AER_ACK_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | no grant; wait for any request
// GRANT   | channel granted, address latched; wait for receiver ack low
// SEND    | aer_req high; wait for ack high
// RELEASE | aer_req low; wait for ack low
// DONE    | event done strobes; wait for granted channel to drop req
module aer_tx_arbiter
   import aer_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int ADDR_W      = aer_addr_w(N_CH),
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [N_CH-1:0]   i_req,
   input  logic [N_CH-1:0]   i_dir_down,
   output logic [N_CH-1:0]   o_gnt,
   output logic              o_fs_sen,
   output logic              o_fe_d,
   output logic [ADDR_W-1:0] o_aer_addr,
   output logic              o_aer_req,
   input  logic              i_aer_ack,
   output logic              o_err
);

   localparam int IDX_W = ADDR_W - 1;

   aer_tx_state_t     r_state;
   logic [N_CH-1:0]   r_gnt;
   logic [IDX_W-1:0]  r_idx;
   logic [IDX_W-1:0]  r_rr_ptr;
   logic [ADDR_W-1:0] r_aer_addr;
   logic              r_aer_req;
   logic              r_fs_sen;
   logic              r_fe_d;
   logic              r_ack_s1;
   logic              r_ack_s2;

   logic [N_CH-1:0]   w_pick;
   logic [IDX_W-1:0]  w_idx;
   logic              w_any;

   aer_rr_arbiter #(
      .N_CH  (N_CH),
      .IDX_W (IDX_W)
   ) u_rr (
      .i_req    (i_req),
      .i_rr_ptr (r_rr_ptr),
      .o_pick   (w_pick),
      .o_idx    (w_idx),
      .o_any    (w_any)
   );

`ifdef AER_ACK_TIMEOUT_EN
   localparam int TO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

   logic [TO_W-1:0] r_to_cnt;
   logic            r_err;
   logic            w_to_hit;

   // Counter covers SEND and RELEASE together; it restarts every time GRANT is left.
   assign w_to_hit = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_to_cnt <= '0;
      end else if (r_state == ST_GRANT) begin
         r_to_cnt <= '0;
      end else if ((r_state == ST_SEND) || (r_state == ST_RELEASE)) begin
         r_to_cnt <= r_to_cnt + TO_W'(1);
      end
   end

   assign o_err = r_err;
`else
   localparam int TO_CYC_UNUSED = TIMEOUT_CYC;
   assign o_err = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= ST_IDLE;
         r_gnt      <= '0;
         r_idx      <= '0;
         r_rr_ptr   <= '0;
         r_aer_addr <= '0;
         r_aer_req  <= 1'b0;
         r_fs_sen   <= 1'b0;
         r_fe_d     <= 1'b0;
         r_ack_s1   <= 1'b0;
         r_ack_s2   <= 1'b0;
`ifdef AER_ACK_TIMEOUT_EN
         r_err      <= 1'b0;
`endif
      end else begin
         r_ack_s1 <= i_aer_ack;
         r_ack_s2 <= r_ack_s1;
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_gnt      <= w_pick;
                  r_idx      <= w_idx;
                  r_aer_addr <= {w_idx, i_dir_down[w_idx]};
                  r_state    <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (!r_ack_s2) begin
                  r_aer_req <= 1'b1;
                  r_fs_sen  <= 1'b1;
                  r_state   <= ST_SEND;
               end
            end
            ST_SEND: begin
`ifdef AER_ACK_TIMEOUT_EN
               if (w_to_hit) begin
                  r_err     <= 1'b1;
                  r_aer_req <= 1'b0;
                  r_fe_d    <= 1'b1;
                  r_state   <= ST_DONE;
               end else
`endif
               if (r_ack_s2) begin
                  r_aer_req <= 1'b0;
                  r_state   <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
`ifdef AER_ACK_TIMEOUT_EN
               if (w_to_hit) begin
                  r_err   <= 1'b1;
                  r_fe_d  <= 1'b1;
                  r_state <= ST_DONE;
               end else
`endif
               if (!r_ack_s2) begin
                  r_fe_d  <= 1'b1;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (!i_req[r_idx]) begin
                  r_gnt    <= '0;
                  r_fs_sen <= 1'b0;
                  r_fe_d   <= 1'b0;
                  r_rr_ptr <= (r_idx == IDX_W'(N_CH - 1)) ? '0 : r_idx + IDX_W'(1);
                  r_state  <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_gnt      = r_gnt;
   assign o_fs_sen   = r_fs_sen;
   assign o_fe_d     = r_fe_d;
   assign o_aer_addr = r_aer_addr;
   assign o_aer_req  = r_aer_req;

endmodule

// File: tb/tb_aer_tx_arbiter.sv
// Randomized bench for aer_tx_arbiter against a transaction-level round-robin model.
// Build with AER_ACK_TIMEOUT_EN defined to also exercise the ack timeout path.
module tb_aer_tx_arbiter;
   import aer_pkg::*;

`ifdef AER_ACK_TIMEOUT_EN
   localparam int DMAX = 1;
   localparam int ECHO = 1;
`else
   localparam int DMAX = 4;
   localparam int ECHO = 3;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = '0;
   logic [3:0] dir = '0;
   logic [3:0] gnt;
   logic       fs_sen;
   logic       fe_d;
   logic [2:0] aer_addr;
   logic       aer_req;
   logic       ack = 1'b0;
   logic       err;

   int n_chk  = 0;
   int n_fail = 0;
   int m_ptr  = 0;

   always #5 clk = ~clk;

   aer_tx_arbiter #(
      .N_CH        (4),
      .TIMEOUT_CYC (10)
   ) dut (
      .i_clk      (clk),
      .i_reset    (rst),
      .i_req      (req),
      .i_dir_down (dir),
      .o_gnt      (gnt),
      .o_fs_sen   (fs_sen),
      .o_fe_d     (fe_d),
      .o_aer_addr (aer_addr),
      .o_aer_req  (aer_req),
      .i_aer_ack  (ack),
      .o_err      (err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int rr_pick(input logic [3:0] r, input int ptr);
      for (int i = 0; i < 4; i++) begin
         if (r[(ptr + i) % 4]) return (ptr + i) % 4;
      end
      return -1;
   endfunction

   function automatic logic [2:0] exp_addr(input int w, input logic [3:0] d);
      logic [1:0] ix;
      ix = 2'(w);
      return {ix, d[w]};
   endfunction

   always @(negedge clk) begin
      if (!rst) chk("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
   end

   task automatic wait_req(input logic lvl, input string tag);
      int n;
      n = 0;
      while (aer_req !== lvl && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk(tag, aer_req, lvl);
   endtask

   task automatic finish_txn(input int w, input logic [2:0] a, input int d);
      int n;
      wait_req(1'b1, "aer_req_rise");
      chk("fs_with_req", fs_sen, 1);
      chk("fe_d_in_send", fe_d, 0);
      chk("addr_send", aer_addr, a);
      repeat (d) @(negedge clk);
      ack = 1'b1;
      wait_req(1'b0, "aer_req_fall");
      chk("fs_release", fs_sen, 1);
      repeat (d) @(negedge clk);
      ack = 1'b0;
      n = 0;
      while (fe_d !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("fe_d_rise", fe_d, 1);
      chk("fs_done", fs_sen, 1);
      chk("gnt_held", gnt, 32'(1 << w));
      chk("addr_done", aer_addr, a);
      chk("aer_req_done", aer_req, 0);
      req[w] = 1'b0;
      @(negedge clk);
      chk("gnt_clear", gnt, 0);
      chk("fe_d_clear", fe_d, 0);
      chk("fs_clear", fs_sen, 0);
      req = '0;
      m_ptr = (w + 1) % 4;
   endtask

   task automatic do_txn(input logic [3:0] rv, input logic [3:0] dv, input bit early, input int d);
      int w;
      w = rr_pick(rv, m_ptr);
      req = rv;
      dir = dv;
      @(negedge clk);
      chk("gnt_lat", gnt, 32'(1 << w));
      chk("addr_grant", aer_addr, exp_addr(w, dv));
      if (early) req[w] = 1'b0;
      finish_txn(w, exp_addr(w, dv), d);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int w;
      repeat (3) @(negedge clk);
      chk("rst_gnt", gnt, 0);
      chk("rst_aer_req", aer_req, 0);
      chk("rst_fs", fs_sen, 0);
      chk("rst_fe", fe_d, 0);
      chk("rst_addr", aer_addr, 0);
      chk("rst_err", err, 0);
      rst = 1'b0;
      @(negedge clk);

      // round robin with all channels requesting: ch0,1,2,3,0
      for (int k = 0; k < 5; k++) begin
         chk("rr_order", rr_pick(4'b1111, m_ptr), k % 4);
         do_txn(4'b1111, 4'b0000, 1'b0, ECHO);
      end

      // single up event on ch1
      m_ptr = 1;
      do_txn(4'b0010, 4'b0000, 1'b0, ECHO);

      // down event on ch3
      do_txn(4'b1000, {POL_DOWN, 3'b000}, 1'b0, ECHO);
      chk("ptr_wrap", m_ptr, 0);

      // receiver still busy at grant
      ack = 1'b1;
      repeat (4) @(negedge clk);
      w = rr_pick(4'b0001, m_ptr);
      req = 4'b0001;
      dir = 4'b0000;
      @(negedge clk);
      chk("stuck_gnt", gnt, 32'(1 << w));
      repeat (6) @(negedge clk);
      chk("stuck_no_req", aer_req, 0);
      chk("stuck_gnt_held", gnt, 32'(1 << w));
      ack = 1'b0;
      finish_txn(w, exp_addr(w, 4'b0000), ECHO);

      // reset in the middle of SEND
      req = 4'b0100;
      dir = 4'b0100;
      wait_req(1'b1, "pre_rst_req");
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_gnt", gnt, 0);
      chk("mid_rst_aer_req", aer_req, 0);
      chk("mid_rst_fs", fs_sen, 0);
      chk("mid_rst_fe", fe_d, 0);
      chk("mid_rst_addr", aer_addr, 0);
      rst = 1'b0;
      req = '0;
      m_ptr = 0;
      @(negedge clk);
      do_txn(4'b1111, 4'b0001, 1'b0, ECHO);

      for (int t = 0; t < 60; t++) begin
         logic [3:0] rv;
         logic [3:0] dv;
         rv = 4'($urandom_range(1, 15));
         dv = 4'($urandom_range(0, 15));
         do_txn(rv, dv, ($urandom_range(0, 3) == 0), $urandom_range(0, DMAX));
      end

`ifdef AER_ACK_TIMEOUT_EN
      begin
         int n;
         w = rr_pick(4'b0001, m_ptr);
         req = 4'b0001;
         dir = 4'b0000;
         wait_req(1'b1, "to_req_rise");
         n = 0;
         while (aer_req === 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
         end
         chk("to_cycles", n, 10);
         chk("to_err", err, 1);
         chk("to_fe_d", fe_d, 1);
         req = '0;
         @(negedge clk);
         chk("to_gnt_clear", gnt, 0);
         repeat (2) @(negedge clk);
         chk("to_err_sticky", err, 1);
      end
`else
      chk("err_tied", err, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
